mult_arbiter: RTL and testbench
===============================

Name: mult_arbiter

Overview:
Sequencer/arbiter sharing one combinational 4x4 multiplier (operands a/b, product p[7:0], c_out) between two requesters. Accepts operand pairs on two valid/ready request channels and grants them round-robin. Drives the shared multiplier's operands, waits a programmable settle time, then returns the registered product with the requester ID on a valid/ready response channel. Sits between client logic and the multiplier instance.

Parameters:
MULT_LAT, 1, cycles operands are held before product is sampled; legal range 1..15

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req0_valid  in  1  requester 0 has an operand pair
req0_ready  out  1  arbiter accepts requester 0 this cycle
req0_a  in  4  requester 0 operand a
req0_b  in  4  requester 0 operand b
req1_valid  in  1  requester 1 has an operand pair
req1_ready  out  1  arbiter accepts requester 1 this cycle
req1_a  in  4  requester 1 operand a
req1_b  in  4  requester 1 operand b
mult_a  out  4  to shared multiplier a
mult_b  out  4  to shared multiplier b
mult_p  in  8  from shared multiplier p
mult_c_out  in  1  from shared multiplier c_out
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_p  out  8  registered product
rsp_c_out  out  1  registered c_out
rsp_id  out  1  requester that issued this result
stat_cnt0  out  16  completed ops, requester 0 (see Optional Feature)
stat_cnt1  out  16  completed ops, requester 1 (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, rr_ptr=0, lat_cnt=0; mult_a, mult_b, rsp_p, rsp_c_out, rsp_id, rsp_valid, stat_cnt0/1 all 0. Reset mid-operation aborts; pending operation and result discarded, no response emitted.
- States: IDLE, WAIT, RESP.
- Ready (combinational from state, valids, rr_ptr): req0_ready = IDLE && (!req1_valid || rr_ptr==0); req1_ready = IDLE && (!req0_valid || rr_ptr==1). Both high in IDLE with no valids; never both high when both valid.
- IDLE: on reqN_valid && reqN_ready: mult_a<=reqN_a, mult_b<=reqN_b, rsp_id<=N, lat_cnt<=MULT_LAT-1, go WAIT.
- WAIT: if lat_cnt==0: rsp_p<=mult_p, rsp_c_out<=mult_c_out, rsp_valid<=1, go RESP; else lat_cnt decrements.
- RESP: rsp_valid, rsp_p, rsp_c_out, rsp_id held stable until rsp_valid && rsp_ready; then rsp_valid<=0, rr_ptr<=~rsp_id, go IDLE. No accept in the same cycle.
- Latency: accept edge T -> rsp_valid high after edge T+MULT_LAT. Max throughput one op per MULT_LAT+2 cycles.
- mult_a/mult_b hold last operands until next accept (not cleared after use).
- Requester may drop valid before acceptance; no effect. Operands sampled only at the accept edge.
- Round-robin fairness: under continuous contention, grants alternate 0,1,0,1...

Optional Feature:
MULT_ARB_STATS_EN: defined -> stat_cnt0/stat_cnt1 increment by 1 on each completed response handshake for rsp_id 0/1, wrapping 0xFFFF->0, cleared by reset. Undefined -> counters not built, stat_cnt0/stat_cnt1 tied to 0; all other behaviour identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles, no valids -> rsp_valid=0, rsp_p=0, mult_a=mult_b=0, req0_ready=req1_ready=1.
- Single op, MULT_LAT=1: req0 a=7,b=9 -> rsp_valid 1 cycle after accept, rsp_p=0x3F, rsp_id=0; consumer holds rsp_ready=1 -> IDLE next cycle.
- Contention: both valid at once, req0 15x15, req1 3x5, rr_ptr=0 -> first rsp_p=225 id=0, then rsp_p=15 id=1; both held valid for 4 ops -> ids 0,1,0,1.
- Backpressure: rsp_ready=0 for 5 cycles with result 6x6 -> rsp_valid stays 1, rsp_p=36 stable, req0_ready=req1_ready=0 throughout.
- Reset mid-op, MULT_LAT=4: rst_n=0 while in WAIT -> no response; next op 2x3 returns rsp_p=6, rsp_id matches its requester.
- Exhaustive sweep via req1: {a,b} counts 0..255 -> every response rsp_p==a*b, rsp_id=1; with MULT_ARB_STATS_EN, stat_cnt1=256, stat_cnt0=0 at end.

Source files
------------

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one combinational 4x4 multiplier between two
// requesters. Operand pairs arrive on two request channels, are granted
// round-robin, held on the multiplier for MULT_LAT cycles, and the product
// is returned with the requester id on a response channel.
//
// Handshake rule for every channel: a transfer happens on the rising clock
// edge where valid and ready are both high; valid never waits on ready, and
// the producer keeps its payload stable while valid is high and unaccepted.
//
// Optional build macro: MULT_ARB_STATS_EN enables the per-requester
// completed-operation counters; without it stat_cnt0/stat_cnt1 read 0.
module mult_arbiter #(
   parameter int MULT_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_a,
   input  logic [3:0]  req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_a,
   input  logic [3:0]  req1_b,
   output logic [3:0]  mult_a,
   output logic [3:0]  mult_b,
   input  logic [7:0]  mult_p,
   input  logic        mult_c_out,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [7:0]  rsp_p,
   output logic        rsp_c_out,
   output logic        rsp_id,
   output logic [15:0] stat_cnt0,
   output logic [15:0] stat_cnt1
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Settle counter load value: counts MULT_LAT-1 down to 0 inside WAIT.
   localparam logic [3:0] LAT_INIT = 4'(MULT_LAT - 1);

   state_t      state_q, state_d;
   logic        rr_ptr_q, rr_ptr_d;
   logic [3:0]  lat_cnt_q, lat_cnt_d;
   logic [3:0]  mult_a_q, mult_a_d;
   logic [3:0]  mult_b_q, mult_b_d;
   logic [7:0]  rsp_p_q, rsp_p_d;
   logic        rsp_c_out_q, rsp_c_out_d;
   logic        rsp_id_q, rsp_id_d;
   logic        rsp_valid_q, rsp_valid_d;

   logic        accept0;
   logic        accept1;
   logic        rsp_fire;

   // Grant logic: only in IDLE; on contention rr_ptr picks the winner.
   always_comb begin
      req0_ready = (state_q == IDLE) && (!req1_valid || !rr_ptr_q);
      req1_ready = (state_q == IDLE) && (!req0_valid ||  rr_ptr_q);
      accept0    = req0_valid && req0_ready;
      accept1    = req1_valid && req1_ready;
      rsp_fire   = rsp_valid_q && rsp_ready;
   end

   // Next-state and datapath update; every register holds by default.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      lat_cnt_d   = lat_cnt_q;
      mult_a_d    = mult_a_q;
      mult_b_d    = mult_b_q;
      rsp_p_d     = rsp_p_q;
      rsp_c_out_d = rsp_c_out_q;
      rsp_id_d    = rsp_id_q;
      rsp_valid_d = rsp_valid_q;
      unique case (state_q)
         IDLE: begin
            if (accept0) begin
               mult_a_d  = req0_a;
               mult_b_d  = req0_b;
               rsp_id_d  = 1'b0;
               lat_cnt_d = LAT_INIT;
               state_d   = WAIT;
            end else if (accept1) begin
               mult_a_d  = req1_a;
               mult_b_d  = req1_b;
               rsp_id_d  = 1'b1;
               lat_cnt_d = LAT_INIT;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            if (lat_cnt_q == 4'd0) begin
               rsp_p_d     = mult_p;
               rsp_c_out_d = mult_c_out;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               lat_cnt_d = lat_cnt_q - 4'd1;
            end
         end
         RESP: begin
            // The requester just served loses priority for the next grant.
            if (rsp_fire) begin
               rsp_valid_d = 1'b0;
               rr_ptr_d    = ~rsp_id_q;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= 1'b0;
         lat_cnt_q   <= 4'd0;
         mult_a_q    <= 4'd0;
         mult_b_q    <= 4'd0;
         rsp_p_q     <= 8'd0;
         rsp_c_out_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         lat_cnt_q   <= lat_cnt_d;
         mult_a_q    <= mult_a_d;
         mult_b_q    <= mult_b_d;
         rsp_p_q     <= rsp_p_d;
         rsp_c_out_q <= rsp_c_out_d;
         rsp_id_q    <= rsp_id_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign mult_a    = mult_a_q;
   assign mult_b    = mult_b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_p     = rsp_p_q;
   assign rsp_c_out = rsp_c_out_q;
   assign rsp_id    = rsp_id_q;

`ifdef MULT_ARB_STATS_EN
   logic [15:0] cnt0_q;
   logic [15:0] cnt1_q;

   // Completed-operation counters, bumped on each response handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt0_q <= 16'd0;
         cnt1_q <= 16'd0;
      end else if (rsp_fire) begin
         if (rsp_id_q) cnt1_q <= cnt1_q + 16'd1;
         else          cnt0_q <= cnt0_q + 16'd1;
      end
   end

   assign stat_cnt0 = cnt0_q;
   assign stat_cnt1 = cnt1_q;
`else
   assign stat_cnt0 = 16'd0;
   assign stat_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter. Models the shared multiplier
// (product plus a parity bit on c_out so that path carries real data),
// drives both request channels and scores responses against an expected
// queue filled at accept time.
module tb_mult_arbiter;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready;
   logic [3:0]  req0_a, req0_b;
   logic        req1_valid, req1_ready;
   logic [3:0]  req1_a, req1_b;
   logic [3:0]  mult_a, mult_b;
   logic [7:0]  mult_p;
   logic        mult_c_out;
   logic        rsp_valid, rsp_ready;
   logic [7:0]  rsp_p;
   logic        rsp_c_out, rsp_id;
   logic [15:0] stat_cnt0, stat_cnt1;

   mult_arbiter #(.MULT_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p), .mult_c_out(mult_c_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p),
      .rsp_c_out(rsp_c_out), .rsp_id(rsp_id),
      .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
   );

   // Shared multiplier model.
   assign mult_p     = {4'b0, mult_a} * {4'b0, mult_b};
   assign mult_c_out = ^mult_p;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [9:0] exp_q[$];      // {id, c_out, p}
   logic       obs_ids[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         acc_cyc = 0;
   int         model_cnt0 = 0;
   int         model_cnt1 = 0;
   logic       prev_valid = 1'b0;
   logic       prev_hs = 1'b0;
   logic [7:0] prev_p = 8'd0;
   logic       prev_id = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // ---------------- driver tasks ----------------
   // Presents one operand pair on the chosen requester until accepted and
   // records the expected result at the accept edge.
   task automatic drive_req(input logic id, input logic [3:0] a, input logic [3:0] b);
      logic [7:0] p;
      bit         done;
      p = {4'b0, a} * {4'b0, b};
      done = 0;
      @(posedge clk); #1;
      if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
      else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         if ((id && req1_ready) || (!id && req0_ready)) begin
            exp_q.push_back({id, ^p, p});
            acc_cyc = cyc + 1;
            done = 1;
         end
      end
      if (!done) check("accept_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      if (id) req1_valid = 1'b0;
      else    req0_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit done;
      done = 0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !rsp_valid) done = 1;
      end
      if (!done) check("drain_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_rsp();
      bit done;
      done = 0;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (rsp_valid) done = 1;
      end
      if (!done) check("rsp_timeout", 32'd1, 32'd0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [9:0] e;
      if (!rst_n) begin
         prev_valid <= 1'b0;
         prev_hs    <= 1'b0;
         model_cnt0 <= 0;
         model_cnt1 <= 0;
      end else begin
         if (req0_valid && req1_valid)
            check("excl_ready", {31'b0, req0_ready && req1_ready}, 32'd0);
         if (rsp_valid && !prev_valid)
            check("latency", cyc - acc_cyc, LAT);
         if (rsp_valid && prev_valid && !prev_hs) begin
            check("hold_p", {24'b0, rsp_p}, {24'b0, prev_p});
            check("hold_id", {31'b0, rsp_id}, {31'b0, prev_id});
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("rsp_p", {24'b0, rsp_p}, {24'b0, e[7:0]});
               check("rsp_c_out", {31'b0, rsp_c_out}, {31'b0, e[8]});
               check("rsp_id", {31'b0, rsp_id}, {31'b0, e[9]});
               obs_ids.push_back(rsp_id);
               if (e[9]) model_cnt1 <= model_cnt1 + 1;
               else      model_cnt0 <= model_cnt0 + 1;
            end
         end
         prev_valid <= rsp_valid;
         prev_hs    <= rsp_valid && rsp_ready;
         prev_p     <= rsp_p;
         prev_id    <= rsp_id;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic exp_ids[6];
      exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      rst_n = 1'b1;
      req0_valid = 1'b0; req0_a = 4'd0; req0_b = 4'd0;
      req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0;
      rsp_ready = 1'b1;

      // Reset state.
      do_reset();
      @(negedge clk);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_rsp_p", {24'b0, rsp_p}, 32'd0);
      check("rst_mult_a", {28'b0, mult_a}, 32'd0);
      check("rst_mult_b", {28'b0, mult_b}, 32'd0);
      check("rst_req0_ready", {31'b0, req0_ready}, 32'd1);
      check("rst_req1_ready", {31'b0, req1_ready}, 32'd1);
      check("rst_stat0", {16'b0, stat_cnt0}, 32'd0);
      check("rst_stat1", {16'b0, stat_cnt1}, 32'd0);

      // Single op from requester 0.
      drive_req(1'b0, 4'd7, 4'd9);
      wait_idle();
      check("idle_req0_ready", {31'b0, req0_ready}, 32'd1);
      check("idle_req1_ready", {31'b0, req1_ready}, 32'd1);
      check("mult_a_held", {28'b0, mult_a}, 32'd7);
      check("mult_b_held", {28'b0, mult_b}, 32'd9);

      // Contention from rr_ptr=0, then four back-to-back contended ops.
      do_reset();
      obs_ids.delete();
      fork
         drive_req(1'b0, 4'd15, 4'd15);
         drive_req(1'b1, 4'd3, 4'd5);
      join
      fork
         begin drive_req(1'b0, 4'd4, 4'd11); drive_req(1'b0, 4'd13, 4'd2); end
         begin drive_req(1'b1, 4'd8, 4'd8);  drive_req(1'b1, 4'd1, 4'd14); end
      join
      wait_idle();
      check("rr_count", obs_ids.size(), 32'd6);
      for (int i = 0; i < 6 && i < obs_ids.size(); i++)
         check("rr_order", {31'b0, obs_ids[i]}, {31'b0, exp_ids[i]});

      // Backpressure: result held while the consumer stalls.
      @(posedge clk); #1 rsp_ready = 1'b0;
      drive_req(1'b0, 4'd6, 4'd6);
      wait_rsp();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", {31'b0, rsp_valid}, 32'd1);
         check("bp_p", {24'b0, rsp_p}, 32'd36);
         check("bp_req0_ready", {31'b0, req0_ready}, 32'd0);
         check("bp_req1_ready", {31'b0, req1_ready}, 32'd0);
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      wait_idle();

      // Reset while the operation is settling: no response may appear.
      drive_req(1'b1, 4'd9, 4'd9);
      do_reset();
      for (int i = 0; i < LAT + 3; i++) begin
         @(negedge clk);
         check("no_rsp_after_rst", {31'b0, rsp_valid}, 32'd0);
      end
      drive_req(1'b1, 4'd2, 4'd3);
      wait_idle();

      // Exhaustive sweep on requester 1.
      do_reset();
      for (int i = 0; i < 256; i++) begin
         logic [7:0] ab;
         ab = 8'(i);
         drive_req(1'b1, ab[7:4], ab[3:0]);
      end
      wait_idle();
`ifdef MULT_ARB_STATS_EN
      check("stat_cnt1", {16'b0, stat_cnt1}, 32'd256);
`else
      check("stat_cnt1", {16'b0, stat_cnt1}, 32'd0);
`endif
      check("stat_cnt0", {16'b0, stat_cnt0}, 32'd0);
      check("sweep_count", model_cnt1, 32'd256);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
